// File: rtl/sdr_cmd_arb.sv
// SDRAM command-bus arbiter: shares the command/address pins between the init,
// refresh, write and read engines and schedules the periodic auto-refresh.
module sdr_cmd_arb #(
  parameter int unsigned REF_PERIOD = 1300,
  parameter int unsigned REF_CNT_W  = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        app_wr_req,
  input  logic        app_rd_req,
  output logic        app_wr_ack,
  output logic        app_rd_ack,
  output logic        ref_req,
  output logic        wr_req,
  output logic        rd_req,
  input  logic        ref_exit,
  input  logic        wr_exit,
  input  logic        rd_exit,
  input  logic [17:0] init_bus,
  input  logic [17:0] ref_bus,
  input  logic [17:0] wr_bus,
  input  logic [17:0] rd_bus,
  output logic [1:0]  sdr_BA,
  output logic [12:0] sdr_A,
  output logic        sdr_nRAS,
  output logic        sdr_nCAS,
  output logic        sdr_nWE,
  output logic        ref_overrun
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_REF   = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  localparam logic [17:0] BUS_NOP = 18'h00007;

  state_t               state_q, state_d;
  logic [REF_CNT_W-1:0] ref_cnt_q, ref_cnt_d;
  logic                 ref_pend_q, ref_pend_d;
  logic                 wr_pend_q, wr_pend_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 last_wr_q, last_wr_d;
  logic                 ref_req_q, ref_req_d;
  logic                 wr_req_q, wr_req_d;
  logic                 rd_req_q, rd_req_d;
  logic                 ref_overrun_q, ref_overrun_d;
  logic [17:0]          cmd_q, cmd_d;
  logic                 ref_tc;
  logic                 grant_ref, grant_wr, grant_rd;

  // Refresh always wins; wr/rd alternate when both are waiting.
  always_comb begin
    grant_ref = 1'b0;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    if (state_q == S_IDLE) begin
      if (ref_pend_q) begin
        grant_ref = 1'b1;
      end else if (wr_pend_q && rd_pend_q) begin
        grant_rd = last_wr_q;
        grant_wr = !last_wr_q;
      end else begin
        grant_wr = wr_pend_q;
        grant_rd = rd_pend_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (init_done) state_d = S_IDLE;
      S_IDLE: begin
        if (grant_ref)     state_d = S_REF;
        else if (grant_wr) state_d = S_WRITE;
        else if (grant_rd) state_d = S_READ;
      end
      S_REF:   if (ref_exit) state_d = S_IDLE;
      S_WRITE: if (wr_exit)  state_d = S_IDLE;
      S_READ:  if (rd_exit)  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // Request set takes priority over the grant-clear in the same cycle.
  always_comb begin
    ref_tc    = (state_q != S_INIT) && (ref_cnt_q == REF_CNT_W'(REF_PERIOD - 1));
    ref_cnt_d = ref_cnt_q + REF_CNT_W'(1);
    if ((state_q == S_INIT) || ref_tc) ref_cnt_d = '0;
    ref_pend_d    = ref_tc     || (ref_pend_q && !grant_ref);
    wr_pend_d     = app_wr_req || (wr_pend_q  && !grant_wr);
    rd_pend_d     = app_rd_req || (rd_pend_q  && !grant_rd);
    ref_overrun_d = ref_overrun_q || (ref_tc && ref_pend_q);
    last_wr_d     = last_wr_q;
    if (grant_wr)      last_wr_d = 1'b1;
    else if (grant_rd) last_wr_d = 1'b0;
  end

  always_comb begin
    ref_req_d = grant_ref;
    wr_req_d  = grant_wr;
    rd_req_d  = grant_rd;
    case (state_q)
      S_INIT:  cmd_d = init_bus;
      S_REF:   cmd_d = ref_bus;
      S_WRITE: cmd_d = wr_bus;
      S_READ:  cmd_d = rd_bus;
      default: cmd_d = BUS_NOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt_q     <= '0;
      ref_pend_q    <= 1'b0;
      wr_pend_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      last_wr_q     <= 1'b0;
      ref_req_q     <= 1'b0;
      wr_req_q      <= 1'b0;
      rd_req_q      <= 1'b0;
      ref_overrun_q <= 1'b0;
      cmd_q         <= BUS_NOP;
    end else begin
      ref_cnt_q     <= ref_cnt_d;
      ref_pend_q    <= ref_pend_d;
      wr_pend_q     <= wr_pend_d;
      rd_pend_q     <= rd_pend_d;
      last_wr_q     <= last_wr_d;
      ref_req_q     <= ref_req_d;
      wr_req_q      <= wr_req_d;
      rd_req_q      <= rd_req_d;
      ref_overrun_q <= ref_overrun_d;
      cmd_q         <= cmd_d;
    end
  end

  assign ref_req     = ref_req_q;
  assign wr_req      = wr_req_q;
  assign rd_req      = rd_req_q;
  assign app_wr_ack  = wr_req_q;
  assign app_rd_ack  = rd_req_q;
  assign ref_overrun = ref_overrun_q;
  assign sdr_BA      = cmd_q[17:16];
  assign sdr_A       = cmd_q[15:3];
  assign sdr_nRAS    = cmd_q[2];
  assign sdr_nCAS    = cmd_q[1];
  assign sdr_nWE     = cmd_q[0];

endmodule

// File: tb/tb_sdr_cmd_arb.sv
// Bench for sdr_cmd_arb: cycle model of the arbitration rules, engine responders,
// and directed scenarios with hand-computed timing checks.
module tb_sdr_cmd_arb;

  localparam int P = 20;

  logic        clk = 1'b0;
  logic        rst_n, init_done, app_wr_req, app_rd_req;
  logic        app_wr_ack, app_rd_ack, ref_req, wr_req, rd_req;
  logic        ref_exit = 1'b0, wr_exit = 1'b0, rd_exit = 1'b0;
  logic [17:0] init_bus = 18'h7, ref_bus = 18'h7, wr_bus = 18'h7, rd_bus = 18'h7;
  logic [1:0]  sdr_BA;
  logic [12:0] sdr_A;
  logic        sdr_nRAS, sdr_nCAS, sdr_nWE, ref_overrun;

  int tests = 0;
  int fails = 0;

  sdr_cmd_arb #(.REF_PERIOD(P), .REF_CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .app_wr_req(app_wr_req), .app_rd_req(app_rd_req),
    .app_wr_ack(app_wr_ack), .app_rd_ack(app_rd_ack),
    .ref_req(ref_req), .wr_req(wr_req), .rd_req(rd_req),
    .ref_exit(ref_exit), .wr_exit(wr_exit), .rd_exit(rd_exit),
    .init_bus(init_bus), .ref_bus(ref_bus), .wr_bus(wr_bus), .rd_bus(rd_bus),
    .sdr_BA(sdr_BA), .sdr_A(sdr_A), .sdr_nRAS(sdr_nRAS), .sdr_nCAS(sdr_nCAS),
    .sdr_nWE(sdr_nWE), .ref_overrun(ref_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Engine responders: each returns its exit pulse a programmable number of
  // cycles after its start pulse; force_exit injects extra exits {ref,wr,rd}.
  int ref_lat = 5, wr_lat = 3, rd_lat = 3;
  int ref_cd = 0, wr_cd = 0, rd_cd = 0;
  logic [2:0] force_exit = 3'b000;

  always @(posedge clk) begin
    #2;
    ref_exit = force_exit[2];
    wr_exit  = force_exit[1];
    rd_exit  = force_exit[0];
    if (ref_req) ref_cd = ref_lat;
    else if (ref_cd > 0) begin ref_cd--; if (ref_cd == 0) ref_exit = 1'b1; end
    if (wr_req) wr_cd = wr_lat;
    else if (wr_cd > 0) begin wr_cd--; if (wr_cd == 0) wr_exit = 1'b1; end
    if (rd_req) rd_cd = rd_lat;
    else if (rd_cd > 0) begin rd_cd--; if (rd_cd == 0) rd_exit = 1'b1; end
    init_bus = 18'($urandom);
    ref_bus  = 18'($urandom);
    wr_bus   = 18'($urandom);
    rd_bus   = 18'($urandom);
  end

  // Model: who owns the bus (init / nobody / engine 0=ref 1=wr 2=rd), what is
  // waiting, and cycles elapsed since init finished.
  bit          m_valid = 1'b0;
  bit          in_init;
  int          active;
  bit          pend [3];
  int          elapsed;
  bit          last_was_wr;
  logic [17:0] e_bus;
  logic [2:0]  e_req;
  logic        e_ovr;

  always @(posedge clk) begin : model
    logic [17:0] eng_bus [3];
    bit          exits [3];
    bit          due, was_init;
    int          g;
    eng_bus[0] = ref_bus;  eng_bus[1] = wr_bus;  eng_bus[2] = rd_bus;
    exits[0]   = ref_exit; exits[1]   = wr_exit; exits[2]   = rd_exit;
    if (!rst_n) begin
      m_valid = 1'b1; in_init = 1'b1; active = -1; elapsed = 0; last_was_wr = 1'b0;
      pend[0] = 1'b0; pend[1] = 1'b0; pend[2] = 1'b0;
      e_bus = 18'h00007; e_req = 3'b000; e_ovr = 1'b0;
    end else begin
      if (in_init)         e_bus = init_bus;
      else if (active < 0) e_bus = 18'h00007;
      else                 e_bus = eng_bus[active];
      due = !in_init && ((elapsed % P) == P - 1);
      g = -1;
      if (!in_init && active < 0) begin
        if (pend[0])                g = 0;
        else if (pend[1] && pend[2]) g = last_was_wr ? 2 : 1;
        else if (pend[1])           g = 1;
        else if (pend[2])           g = 2;
      end
      e_req = (g < 0) ? 3'b000 : (3'b100 >> g);
      if (due && pend[0]) e_ovr = 1'b1;
      was_init = in_init;
      if (in_init) in_init = !init_done;
      else if (active >= 0) begin
        if (exits[active]) active = -1;
      end else if (g >= 0) begin
        active = g;
        pend[g] = 1'b0;
        if (g != 0) last_was_wr = (g == 1);
      end
      if (due)        pend[0] = 1'b1;
      if (app_wr_req) pend[1] = 1'b1;
      if (app_rd_req) pend[2] = 1'b1;
      elapsed = was_init ? 0 : elapsed + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("cmd_bus", 32'({sdr_BA, sdr_A, sdr_nRAS, sdr_nCAS, sdr_nWE}), 32'(e_bus));
      check("req_pulses", 32'({ref_req, wr_req, rd_req}), 32'(e_req));
      check("app_acks", 32'({app_wr_ack, app_rd_ack}), 32'(e_req[1:0]));
      check("overrun", 32'(ref_overrun), 32'(e_ovr));
    end
  end

  task automatic wait_for(input logic [2:0] mask, input int limit,
                          output logic [2:0] seen, output int n);
    n = 0;
    seen = 3'b000;
    while (seen == 3'b000 && n < limit) begin
      @(negedge clk);
      n++;
      seen = {ref_req, wr_req, rd_req} & mask;
    end
    if (seen == 3'b000) begin
      tests++;
      fails++;
      $display("FAIL wait_%b: no pulse within %0d cycles, expected one", mask, limit);
    end
  endtask

  task automatic pulse_app(input logic wr, input logic rd);
    app_wr_req = wr;
    app_rd_req = rd;
    @(negedge clk);
    app_wr_req = 1'b0;
    app_rd_req = 1'b0;
  endtask

  initial begin
    logic [2:0] seen;
    int n, wcnt, acnt;
    rst_n = 1'b0; init_done = 1'b0; app_wr_req = 1'b0; app_rd_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd", 32'({sdr_BA, sdr_A, sdr_nRAS, sdr_nCAS, sdr_nWE}), 32'h7);
    check("rst_pulses", 32'({ref_req, wr_req, rd_req, app_wr_ack, app_rd_ack, ref_overrun}), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Refresh cadence after init completes.
    init_done = 1'b1;
    wait_for(3'b100, 60, seen, n);
    check("first_ref_latency", 32'(n), 32'd22);
    wait_for(3'b100, 60, seen, n);
    check("ref_period", 32'(n), 32'd20);
    check("no_overrun", 32'(ref_overrun), 32'd0);

    // Simultaneous write+read from idle: write first, read 2 cycles after wr_exit.
    repeat (7) @(negedge clk);
    pulse_app(1'b1, 1'b1);
    wait_for(3'b011, 40, seen, n);
    check("pair_first_is_wr", 32'(seen), 32'b010);
    check("pair_wr_latency", 32'(n), 32'd1);
    check("pair_wr_ack", 32'({app_wr_ack, app_rd_ack}), 32'b10);
    wait_for(3'b001, 40, seen, n);
    check("pair_rd_after_exit", 32'(n), 32'd5);
    check("pair_rd_ack", 32'({app_wr_ack, app_rd_ack}), 32'b01);

    // Lone write, then both pending with last grant a write: read goes first.
    repeat (3) @(negedge clk);
    pulse_app(1'b1, 1'b0);
    wait_for(3'b011, 40, seen, n);
    check("solo_wr", 32'(seen), 32'b010);
    repeat (2) @(negedge clk);
    pulse_app(1'b1, 1'b1);
    wait_for(3'b011, 60, seen, n);
    check("alt_first_is_rd", 32'(seen), 32'b001);
    wait_for(3'b011, 60, seen, n);
    check("alt_second_is_wr", 32'(seen), 32'b010);

    // Refresh comes due during a long write with a read queued: refresh first.
    wr_lat = 15;
    wait_for(3'b100, 60, seen, n);
    pulse_app(1'b1, 1'b0);
    wait_for(3'b010, 40, seen, n);
    pulse_app(1'b0, 1'b1);
    wait_for(3'b101, 60, seen, n);
    check("ref_before_rd", 32'(seen), 32'b100);
    wait_for(3'b101, 60, seen, n);
    check("rd_after_ref", 32'(seen), 32'b001);

    // Three write requests during a read merge into one grant; stray exits ignored.
    rd_lat = 12;
    pulse_app(1'b0, 1'b1);
    wait_for(3'b001, 60, seen, n);
    pulse_app(1'b1, 1'b0);
    force_exit = 3'b110;
    pulse_app(1'b1, 1'b0);
    force_exit = 3'b000;
    pulse_app(1'b1, 1'b0);
    wcnt = 0;
    acnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      wcnt += int'(wr_req);
      acnt += int'(app_wr_ack);
    end
    check("merged_wr_count", 32'(wcnt), 32'd1);
    check("merged_ack_count", 32'(acnt), 32'd1);

    // Refresh engine stalls past two periods: overrun sets and sticks.
    ref_lat = 1000;
    wait_for(3'b100, 60, seen, n);
    repeat (45) @(negedge clk);
    check("overrun_set", 32'(ref_overrun), 32'd1);
    ref_lat = 5;
    force_exit = 3'b100;
    @(negedge clk);
    force_exit = 3'b000;
    repeat (30) @(negedge clk);
    check("overrun_sticky", 32'(ref_overrun), 32'd1);

    // Reset in the middle of a write abandons the grant at once.
    wr_lat = 10;
    pulse_app(1'b1, 1'b0);
    wait_for(3'b010, 60, seen, n);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_cmd", 32'({sdr_BA, sdr_A, sdr_nRAS, sdr_nCAS, sdr_nWE}), 32'h7);
    check("midrst_pulses", 32'({ref_req, wr_req, rd_req, app_wr_ack, app_rd_ack}), 32'h0);
    check("midrst_overrun", 32'(ref_overrun), 32'd0);
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdr_cmd_arb.md
Name: sdr_cmd_arb

Overview:
Command-bus arbiter and scheduler for the single-rank SDRAM controller. It shares the SDRAM command/address pins between four engines: init, auto-refresh, write and read. It generates the periodic refresh request and starts each engine with a one-cycle request pulse. It holds the grant until that engine's exit pulse and drives the registered command pins from the granted engine.

Parameters:
REF_PERIOD, 1300, clk cycles between refresh requests (7.8 us at 167 MHz)
REF_CNT_W, 11, width of refresh timer; must satisfy 2^REF_CNT_W > REF_PERIOD

Ports:
clk  input  1  controller clock, 167 MHz
rst_n  input  1  synchronous active-low reset, sampled on rising clk
init_done  input  1  level from init engine; high once power-up sequence is complete
app_wr_req  input  1  user write request pulse
app_rd_req  input  1  user read request pulse
app_wr_ack  output  1  one-cycle pulse when the write is granted
app_rd_ack  output  1  one-cycle pulse when the read is granted
ref_req  output  1  one-cycle start pulse to refresh engine
wr_req  output  1  one-cycle start pulse to write engine (its sdr_wr_req)
rd_req  output  1  one-cycle start pulse to read engine
ref_exit  input  1  refresh engine done pulse
wr_exit  input  1  write engine done pulse
rd_exit  input  1  read engine done pulse
init_bus  input  18  init engine {BA[1:0],A[12:0],nRAS,nCAS,nWE}
ref_bus  input  18  refresh engine bundle, same packing
wr_bus  input  18  write engine bundle, same packing
rd_bus  input  18  read engine bundle, same packing
sdr_BA  output  2  SDRAM bank address
sdr_A  output  13  SDRAM address
sdr_nRAS  output  1  SDRAM nRAS
sdr_nCAS  output  1  SDRAM nCAS
sdr_nWE  output  1  SDRAM nWE
ref_overrun  output  1  sticky: a refresh came due while the previous one was still pending

Behaviour:
- Synchronous reset only. rst_n low at a clk edge forces:
  - state S_INIT, all pend flags 0, refresh timer 0, last_wr 0
  - all req/ack pulses 0, ref_overrun 0
  - sdr_BA=0, sdr_A=0, {nRAS,nCAS,nWE}=111 (NOP)
  - Reset mid-operation abandons the grant immediately; no exit pulse is awaited.
- States: S_INIT, S_IDLE, S_REF, S_WRITE, S_READ (3-bit encoding).
- S_INIT: moves to S_IDLE the cycle after init_done is sampled high. app requests are latched as pending during S_INIT.
- S_IDLE picks one grant per cycle. Priority: ref_pend first, then wr/rd.
  - Only one of wr/rd pending: grant it.
  - Both pending: grant read if last_wr=1, else write.
  - last_wr updates on each wr/rd grant.
- Grant at edge t:
  - State enters S_REF/S_WRITE/S_READ at t+1.
  - The matching req is high for exactly the cycle after t.
  - For wr/rd, app_*_ack is high in the same cycle as the req.
  - The pend flag clears at t+1.
- S_REF/S_WRITE/S_READ: hold until the matching exit is sampled high, then go to S_IDLE.
  - A new grant is possible on the cycle after returning to S_IDLE, giving a minimum 1-cycle idle gap.
  - Exit pulses from non-granted engines are ignored.
- Pending flags:
  - app_wr_req sets wr_pend and app_rd_req sets rd_pend in any state.
  - Set has priority over the grant-clear in the same cycle.
  - A request while its flag is already set is merged: one grant, one ack.
- Refresh timer:
  - Held at 0 in S_INIT.
  - Afterwards counts 0..REF_PERIOD-1 and wraps to 0.
  - At terminal count, sets ref_pend.
  - If ref_pend is already 1 at terminal count, ref_overrun sets and stays set until reset.
- Command output is a registered mux with 1-cycle latency. sdr_* at t+1 equals, at t:
  - S_INIT: init_bus
  - S_REF: ref_bus
  - S_WRITE: wr_bus
  - S_READ: rd_bus
  - S_IDLE: BA=0, A=0, cmd=111
- Engines drive NOP on their bundle when not running. The arbiter does not decode commands.

Test Plan:
- Reset, then init_done high at cycle 10 → sdr_* mirrors init_bus with 1-cycle lag until cycle 11; state S_IDLE at 11; ref timer starts from 0.
- REF_PERIOD=20, no app traffic → ref_req pulse 21 cycles after leaving init, repeating every 20 cycles; ref_exit returned 5 cycles after each req → ref_overrun stays 0.
- app_wr_req and app_rd_req in the same cycle from IDLE → wr_req+app_wr_ack first; after wr_exit, rd_req+app_rd_ack on the 2nd cycle after exit. Repeat with both pending again → read is granted first.
- Refresh due while write is active, plus app_rd_req pending → after wr_exit, ref_req before rd_req; sdr_* shows ref_bus during S_REF.
- app_wr_req pulsed 3 times while S_READ is active → exactly one wr_req/app_wr_ack after rd_exit.
- Hold ref_exit low beyond 2×REF_PERIOD → ref_overrun=1 and sticky; rst_n low for one cycle mid-S_WRITE → next cycle all outputs at reset values, state S_INIT.
